uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
Parametrised UART transmitter with an integrated write-side FIFO and runtime-selectable framing: data width, parity mode, stop bits and baud divisor.
Sits between a host/bus write port and the serial TX pin.
Successor to the fixed 8-bit, fixed-divisor transmitter: it adds FIFO depth, parity enable, runtime divisor, overflow reporting and status outputs.

Parameters:
DATA_W, 8, data bits per frame (legal 5..9)
FIFO_DEPTH, 16, FIFO entries (power of two, >=2)
DIV_W, 16, width of baud divisor input
CNT_W, $clog2(FIFO_DEPTH)+1, derived, width of level output (not overridable)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  push request
wr_data  in  DATA_W  word to push
baud_div  in  DIV_W  clk cycles per bit; values <2 treated as 2
parity_en  in  1  1 = append parity bit
odd_parity  in  1  1 = odd parity, 0 = even (ignored if !parity_en)
two_stop  in  1  1 = two stop bits
tx_en  in  1  1 = allow new frames to start
tx_out  out  1  serial line, idle high
busy  out  1  frame in progress
full  out  1  FIFO holds FIFO_DEPTH words
empty  out  1  FIFO holds 0 words
level  out  CNT_W  current FIFO occupancy
overflow  out  1  one-cycle pulse: write dropped because full

Behaviour:
- Reset: tx_out=1, busy=0, full=0, empty=1, level=0, overflow=0, pointers/counters=0, state IDLE. Reset mid-frame aborts the frame; tx_out=1 after that edge; FIFO contents discarded.
- FIFO push: wr_en && !full writes at wr_ptr. full/level/empty are registered, so a push on cycle N is visible on cycle N+1.
- wr_en && full: word dropped, overflow=1 for the next cycle only, contents unchanged. No write-through when full, even if a pop occurs in the same cycle.
- Simultaneous push (not full) and pop: both occur and level is unchanged.
- Pointers wrap modulo FIFO_DEPTH; level saturates at neither end (guarded by full/empty).
- FSM states (shared enum): IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1, busy=0. If tx_en && !empty: pop head into shift reg; latch baud_div, parity_en, odd_parity, two_stop into frame config; goto START. busy=1 from next cycle.
- Latency: tx_out falls exactly 1 cycle after the IDLE cycle that sees tx_en && !empty.
- START: tx_out=0 for one bit time, then DATA.
- DATA: DATA_W bits, LSB first, one bit time each. Bit counter runs 0..DATA_W-1. Then PARITY if latched parity_en, else STOP.
- PARITY: tx_out = ^data (even) or ~^data (odd) over DATA_W bits; one bit time.
- STOP: tx_out=1 for 1 or 2 bit times, then IDLE. If tx_en && !empty in that IDLE cycle, the next START begins, giving exactly 1 extra idle cycle between frames.
- Bit time: baud counter counts 0..div-1 (div = max(latched baud_div,2)) and advances bit on terminal count. Config input changes mid-frame have no effect until the next frame.
- tx_en deasserted mid-frame: current frame completes; no new frame starts.
- Frame length in cycles: div*(1+DATA_W+parity_en+1+two_stop).

Decomposition:
- Package uart_pkg: tx_state_t enum (IDLE,START,DATA,PARITY,STOP); MIN_BAUD_DIV=2 constant; parity helper function (data, odd) -> bit.
- One sub-module, sync_fifo (DATA_W, FIFO_DEPTH): push/pop, full/empty/level, overflow pulse.
- uart_tx_core holds the FSM, baud counter, bit counter, shift register and config latch.

Test Plan:
- Reset then idle: rst 2 cycles, no writes -> tx_out=1, busy=0, empty=1, level=0 for 100 cycles.
- 8N1, baud_div=4, push 0xA5, tx_en=1 -> tx_out 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 total); first 0 appears 1 cycle after the pop cycle.
- 8E1 then 8O2, baud_div=4, push 0xA5 twice -> parity bit 0 (even), 44 cycles; next frame parity bit 1 (odd), two stop bits, 48 cycles; 1 idle cycle between frames.
- FIFO_DEPTH=16, tx_en=0, push 17 words 0x00..0x10 -> full=1, level=16 after the 16th push; overflow pulses 1 cycle on the 17th; enable tx -> 0x00..0x0F sent in order, 0x10 never sent.
- baud_div changed 4->8 mid-frame -> current frame keeps 4-cycle bits; next frame uses 8. baud_div=0 -> 2-cycle bits.
- rst asserted during DATA bit 3 -> tx_out=1, busy=0, empty=1 on the next cycle; no further bits are transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
//   tx_state_t   : transmitter FSM states
//   MIN_BAUD_DIV : smallest usable clk-cycles-per-bit value
//   MAX_DATA_W   : widest supported data word
//   parity_bit() : parity bit for a zero-extended data word
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int MIN_BAUD_DIV = 2;
    localparam int MAX_DATA_W   = 9;

    // Zero-extension of narrower words leaves the XOR reduction unchanged.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                        input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_core_sync_fifo.sv
// Synchronous write-side FIFO for the UART transmitter.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   wr_en/wr_data : push request and word
//   rd_en         : pop request (head is presented on rd_data combinationally)
//   full/empty    : registered occupancy flags
//   level         : registered occupancy count
//   overflow      : one-cycle pulse after a push attempt while full
module sync_fifo #(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  level,
    output logic              overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_level;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;

    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_level_next;

    // A push is refused when full even if a pop frees a slot this cycle.
    assign w_push = wr_en && !r_full;
    assign w_pop  = rd_en && !r_empty;

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level    <= w_level_next;
            r_full     <= (w_level_next == CNT_W'(FIFO_DEPTH));
            r_empty    <= (w_level_next == '0);
            r_overflow <= wr_en && r_full;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign rd_data  = r_mem[r_rd_ptr];
    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter with write FIFO and per-frame latched framing config.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   wr_en, wr_data           : FIFO push port
//   baud_div                 : clk cycles per bit (values below 2 act as 2)
//   parity_en, odd_parity    : parity enable / odd select
//   two_stop                 : two stop bits when set
//   tx_en                    : permits new frames to start
//   tx_out                   : serial line, idle high (registered)
//   busy                     : frame in progress
//   full, empty, level       : FIFO status
//   overflow                 : one-cycle pulse, write dropped while full
//
// state  | meaning
// IDLE   | line high, waiting for tx_en and a queued word
// START  | start bit (low) for one bit time
// DATA   | data bits LSB first, one bit time each
// PARITY | parity bit for one bit time (only when latched parity_en)
// STOP   | one or two high stop bits, then back to IDLE
module uart_tx_core
    import uart_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 16,
    parameter  int DIV_W      = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              parity_en,
    input  logic              odd_parity,
    input  logic              two_stop,
    input  logic              tx_en,
    output logic              tx_out,
    output logic              busy,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  level,
    output logic              overflow
);

    localparam int BIT_W = $clog2(DATA_W);

    tx_state_t         r_state;
    logic [DIV_W-1:0]  r_baud_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_stop_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DIV_W-1:0]  r_div;
    logic              r_par_en;
    logic              r_two_stop;
    logic              r_parity_bit;
    logic              r_tx_out;

    tx_state_t         w_state_next;
    logic [DIV_W-1:0]  w_baud_next;
    logic [BIT_W-1:0]  w_bit_next;
    logic              w_stop_next;
    logic [DATA_W-1:0] w_shift_next;
    logic              w_load;
    logic              w_tc;
    logic              w_tx_next;
    logic [DATA_W-1:0] w_fifo_rdata;
    logic              w_fifo_empty;
    logic [DIV_W-1:0]  w_div_eff;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (w_load),
        .rd_data  (w_fifo_rdata),
        .full     (full),
        .empty    (w_fifo_empty),
        .level    (level),
        .overflow (overflow)
    );

    assign w_div_eff = (baud_div < DIV_W'(MIN_BAUD_DIV)) ? DIV_W'(MIN_BAUD_DIV) : baud_div;
    assign w_tc      = (r_baud_cnt == r_div - DIV_W'(1));

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt;
        w_bit_next   = r_bit_cnt;
        w_stop_next  = r_stop_cnt;
        w_shift_next = r_shift;
        w_load       = 1'b0;

        case (r_state)
            IDLE: begin
                if (tx_en && !w_fifo_empty) begin
                    w_load       = 1'b1;
                    w_shift_next = w_fifo_rdata;
                    w_baud_next  = '0;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_tc) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = DATA;
                end else begin
                    w_baud_next = r_baud_cnt + DIV_W'(1);
                end
            end
            DATA: begin
                if (w_tc) begin
                    w_baud_next = '0;
                    if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
                        w_stop_next  = 1'b0;
                        w_state_next = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bit_next   = r_bit_cnt + BIT_W'(1);
                        w_shift_next = r_shift >> 1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + DIV_W'(1);
                end
            end
            PARITY: begin
                if (w_tc) begin
                    w_baud_next  = '0;
                    w_stop_next  = 1'b0;
                    w_state_next = STOP;
                end else begin
                    w_baud_next = r_baud_cnt + DIV_W'(1);
                end
            end
            STOP: begin
                if (w_tc) begin
                    w_baud_next = '0;
                    if (r_two_stop && !r_stop_cnt) begin
                        w_stop_next = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + DIV_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so tx_out is a clean flop output.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = r_parity_bit;
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_shift      <= '0;
            r_div        <= DIV_W'(MIN_BAUD_DIV);
            r_par_en     <= 1'b0;
            r_two_stop   <= 1'b0;
            r_parity_bit <= 1'b0;
            r_tx_out     <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_stop_cnt <= w_stop_next;
            r_shift    <= w_shift_next;
            r_tx_out   <= w_tx_next;
            if (w_load) begin
                r_div        <= w_div_eff;
                r_par_en     <= parity_en;
                r_two_stop   <= two_stop;
                r_parity_bit <= parity_bit(MAX_DATA_W'(w_fifo_rdata), odd_parity);
            end
        end
    end

    assign tx_out = r_tx_out;
    assign busy   = (r_state != IDLE);
    assign empty  = w_fifo_empty;

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;
    localparam int CNT_W      = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DIV_W-1:0]  baud_div = 16'd4;
    logic              parity_en = 1'b0;
    logic              odd_parity = 1'b0;
    logic              two_stop = 1'b0;
    logic              tx_en = 1'b0;
    logic              tx_out;
    logic              busy;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  level;
    logic              overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Expected {tx_out, busy} per clock cycle, sampled at negedge.
    logic [1:0] exp_q[$];

    uart_tx_core #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .odd_parity (odd_parity),
        .two_stop   (two_stop),
        .tx_en      (tx_en),
        .tx_out     (tx_out),
        .busy       (busy),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a frame is a list of line levels, each held for div cycles.
    task automatic add_frame(input logic [DATA_W-1:0] data, input int div,
                             input bit pen, input bit odd, input bit two);
        int d;
        int ones;
        logic bits[$];
        d = (div < 2) ? 2 : div;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) begin
            bits.push_back(data[i]);
            if (data[i]) ones++;
        end
        // Even parity makes the total count of ones even; odd makes it odd.
        if (pen) bits.push_back(odd ? ((ones % 2) == 0) : ((ones % 2) == 1));
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int c = 0; c < d; c++) exp_q.push_back({bits[b], 1'b1});
        end
    endtask

    task automatic add_idle();
        exp_q.push_back(2'b10);
    endtask

    task automatic run_expect(input int n);
        logic [1:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check("wave_underrun", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wave", {tx_out, busy}, e);
            end
        end
    endtask

    task automatic run_all();
        run_expect(exp_q.size());
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] words[$];
        int                nw;
        int                rdiv;
        bit                rpen, rodd, rtwo;

        // Reset then idle
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle", {tx_out, busy, empty, level, overflow, full},
                  {1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0});
        end

        // 8N1, div 4, 0xA5; first low cycle right after the pop cycle
        baud_div = 16'd4; parity_en = 0; odd_parity = 0; two_stop = 0;
        push(8'hA5);
        check("level_after_push", level, 32'd1);
        check("empty_after_push", empty, 32'd0);
        add_frame(8'hA5, 4, 0, 0, 0);
        add_idle();
        tx_en = 1'b1;
        run_all();
        tx_en = 1'b0;
        check("empty_after_8n1", empty, 32'd1);

        // 8E1 then 8O2 back to back; config changed during the first frame
        parity_en = 1; odd_parity = 0; two_stop = 0;
        push(8'hA5);
        push(8'hA5);
        add_frame(8'hA5, 4, 1, 0, 0);
        add_idle();
        add_frame(8'hA5, 4, 1, 1, 1);
        add_idle();
        tx_en = 1'b1;
        run_expect(20);
        odd_parity = 1; two_stop = 1;
        run_all();
        tx_en = 1'b0;
        parity_en = 0; odd_parity = 0; two_stop = 0;

        // Fill FIFO to full, then overflow
        for (int i = 0; i < 16; i++) push(8'(i));
        check("full_at_16", full, 32'd1);
        check("level_at_16", level, 32'd16);
        check("no_ovf_at_16", overflow, 32'd0);
        push(8'h10);
        check("ovf_pulse", overflow, 32'd1);
        check("level_after_ovf", level, 32'd16);
        @(negedge clk);
        check("ovf_clear", overflow, 32'd0);
        baud_div = 16'd2;
        for (int i = 0; i < 16; i++) begin
            add_frame(8'(i), 2, 0, 0, 0);
            add_idle();
        end
        tx_en = 1'b1;
        run_all();
        run_expect(0);
        check("drained_empty", empty, 32'd1);
        check("drained_level", level, 32'd0);
        repeat (10) begin
            @(negedge clk);
            check("no_dropped_word", {tx_out, busy}, 32'b10);
        end
        tx_en = 1'b0;

        // Divisor change mid-frame applies to the next frame only
        baud_div = 16'd4;
        push(8'h3C);
        push(8'hC3);
        add_frame(8'h3C, 4, 0, 0, 0);
        add_idle();
        add_frame(8'hC3, 8, 0, 0, 0);
        add_idle();
        tx_en = 1'b1;
        run_expect(10);
        baud_div = 16'd8;
        run_all();
        tx_en = 1'b0;

        // Divisor 0 behaves as 2
        baud_div = 16'd0;
        push(8'h96);
        add_frame(8'h96, 0, 0, 0, 0);
        add_idle();
        tx_en = 1'b1;
        run_all();
        tx_en = 1'b0;

        // Randomized bursts against the reference
        for (int burst = 0; burst < 6; burst++) begin
            nw   = $urandom_range(1, 6);
            rdiv = $urandom_range(0, 6);
            rpen = 1'($urandom_range(0, 1));
            rodd = 1'($urandom_range(0, 1));
            rtwo = 1'($urandom_range(0, 1));
            words.delete();
            for (int i = 0; i < nw; i++) begin
                words.push_back(8'($urandom));
                push(words[i]);
            end
            check("rand_level", level, 32'(nw));
            baud_div = 16'(rdiv); parity_en = rpen; odd_parity = rodd; two_stop = rtwo;
            foreach (words[i]) begin
                add_frame(words[i], rdiv, rpen, rodd, rtwo);
                add_idle();
            end
            tx_en = 1'b1;
            run_all();
            tx_en = 1'b0;
        end
        baud_div = 16'd4; parity_en = 0; odd_parity = 0; two_stop = 0;

        // Reset during data bit 3 aborts frame and discards queued word
        push(8'h5A);
        push(8'h12);
        add_frame(8'h5A, 4, 0, 0, 0);
        tx_en = 1'b1;
        run_expect(4 + 3 * 4 + 2);
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_frame", {tx_out, busy, empty, level}, {1'b1, 1'b0, 1'b1, 5'd0});
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("post_rst_idle", {tx_out, busy}, 32'b10);
        end
        tx_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
